// File: rtl/cpu_bus_arbiter_pkg.sv
// rtl/cpu_bus_arbiter_pkg.sv - shared types and constants for the CPU bus arbiter
//
// Contents:
//   BUS_WIDTH          address / data width of every port
//   state_t            arbiter FSM state (idle, granted to port 0, granted to port 1)
//   GRANT_*            one-hot debug grant encodings
//   BUS_TIMEOUT_RDATA  read data returned to a requester whose transaction was killed
//   grant_onehot()     state -> one-hot debug grant
package cpu_bus_arbiter_pkg;

  localparam int BUS_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT_0 = 2'd1,
    ST_GRANT_1 = 2'd2
  } state_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_0    = 2'b01;
  localparam logic [1:0] GRANT_1    = 2'b10;

  localparam logic [BUS_WIDTH-1:0] BUS_TIMEOUT_RDATA = 32'h0;

  function automatic logic [1:0] grant_onehot(input state_t st);
    case (st)
      ST_GRANT_0: grant_onehot = GRANT_0;
      ST_GRANT_1: grant_onehot = GRANT_1;
      default:    grant_onehot = GRANT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/cpu_bus_arbiter_if.sv
// rtl/cpu_bus_arbiter_if.sv - one bus transaction channel (requester side or system bus side)
//
// Signals:
//   request  master -> slave   transaction requested, held until ready
//   rw       master -> slave   1 = write
//   address  master -> slave   word address
//   wdata    master -> slave   write data
//   ready    slave  -> master  one-cycle completion pulse
//   rdata    slave  -> master  read data, valid while ready
// Modports:
//   master   the side that issues transactions (a requester, or the arbiter towards the bus)
//   slave    the side that completes them (the arbiter towards a requester, or the bus)
interface cpu_bus_arbiter_if;
  import cpu_bus_arbiter_pkg::*;

  logic                 request;
  logic                 rw;
  logic [BUS_WIDTH-1:0] address;
  logic [BUS_WIDTH-1:0] wdata;
  logic                 ready;
  logic [BUS_WIDTH-1:0] rdata;

  modport master (
    output request, rw, address, wdata,
    input  ready, rdata
  );

  modport slave (
    input  request, rw, address, wdata,
    output ready, rdata
  );

endinterface

// File: rtl/cpu_bus_timeout_counter.sv
// rtl/cpu_bus_timeout_counter.sv - saturating watchdog counter for a bus grant
//
// Parameters:
//   TIMEOUT   number of stalled grant cycles after which expired is raised (must be > 0)
// Ports:
//   i_clock   system clock
//   i_reset   asynchronous active-low reset
//   clear     zero the count (wins over enable)
//   enable    count one stalled cycle
//   expired   count has reached TIMEOUT-1, i.e. the current cycle is the TIMEOUT-th stalled one
module cpu_bus_timeout_counter #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] SAT  = CW'(TIMEOUT);

  logic [CW-1:0] count;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != SAT)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/cpu_bus_arbiter.sv
// rtl/cpu_bus_arbiter.sv - two-port CPU system bus arbiter with transaction watchdog
//
// Shares one system bus between instruction fetch (m0) and the data stage (m1).
// One transaction at a time; arbitration is registered in IDLE, and at least one
// IDLE cycle separates consecutive grants.
//
// Parameters:
//   TIMEOUT   stalled grant cycles before forced termination; 0 disables the watchdog
// Configuration macro:
//   CPU_BUS_ARBITER_ROUND_ROBIN_EN  defined: ties go to the port not granted last;
//                                   undefined: ties always go to m1
// Ports:
//   i_clock   system clock, rising edge
//   i_reset   asynchronous active-low reset
//   m0        requester port 0 (instruction fetch), slave view
//   m1        requester port 1 (data stage), slave view
//   bus       system bus, master view
//   o_grant   debug: one-hot current grant, 0 when idle
//   o_timeout debug: one-cycle pulse when the watchdog kills a transaction
module cpu_bus_arbiter
  import cpu_bus_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  cpu_bus_arbiter_if.slave        m0,
  cpu_bus_arbiter_if.slave        m1,
  cpu_bus_arbiter_if.master       bus,
  output logic [1:0]              o_grant,
  output logic                    o_timeout
);

  state_t state;
  state_t state_next;
  state_t tie_state;

  logic cur_request;
  logic wd_clear;
  logic wd_enable;
  logic wd_expired;
  logic timeout_fire;

  // ---------------------------------------------------------------------------
  // Tie-break between simultaneous requests
  // ---------------------------------------------------------------------------
`ifdef CPU_BUS_ARBITER_ROUND_ROBIN_EN
  logic last_grant;  // 0 = m0, 1 = m1; only real completions update it

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      last_grant <= 1'b0;
    end else if (bus.ready && (state == ST_GRANT_0)) begin
      last_grant <= 1'b0;
    end else if (bus.ready && (state == ST_GRANT_1)) begin
      last_grant <= 1'b1;
    end
  end

  assign tie_state = last_grant ? ST_GRANT_0 : ST_GRANT_1;
`else
  assign tie_state = ST_GRANT_1;
`endif

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
  always_comb begin
    cur_request = 1'b0;
    case (state)
      ST_GRANT_0: cur_request = m0.request;
      ST_GRANT_1: cur_request = m1.request;
      default:    cur_request = 1'b0;
    endcase
  end

  // Counting restarts from zero for every grant because IDLE always separates grants.
  assign wd_clear  = (state == ST_IDLE) || bus.ready;
  assign wd_enable = (state != ST_IDLE) && !bus.ready;

  generate
    if (TIMEOUT > 0) begin : g_watchdog
      cpu_bus_timeout_counter #(
        .TIMEOUT (TIMEOUT)
      ) u_timeout_counter (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
      );
    end else begin : g_no_watchdog
      assign wd_expired = 1'b0;
    end
  endgenerate

  // A real ready beats the watchdog; an aborted request is not answered at all.
  assign timeout_fire = wd_expired && (state != ST_IDLE) && !bus.ready && cur_request;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: begin
        if (m0.request && m1.request) begin
          state_next = tie_state;
        end else if (m1.request) begin
          state_next = ST_GRANT_1;
        end else if (m0.request) begin
          state_next = ST_GRANT_0;
        end
      end
      ST_GRANT_0: begin
        if (bus.ready || timeout_fire || !m0.request) begin
          state_next = ST_IDLE;
        end
      end
      ST_GRANT_1: begin
        if (bus.ready || timeout_fire || !m1.request) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (bus mux and response routing are combinational)
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.request = 1'b0;
    bus.rw      = 1'b0;
    bus.address = '0;
    bus.wdata   = '0;
    m0.ready    = 1'b0;
    m0.rdata    = '0;
    m1.ready    = 1'b0;
    m1.rdata    = '0;
    o_grant     = grant_onehot(state);
    o_timeout   = timeout_fire;

    unique case (state)
      ST_GRANT_0: begin
        bus.request = m0.request && !timeout_fire;
        bus.rw      = m0.rw;
        bus.address = m0.address;
        bus.wdata   = m0.wdata;
        m0.ready    = bus.ready || timeout_fire;
        m0.rdata    = bus.ready ? bus.rdata : BUS_TIMEOUT_RDATA;
      end
      ST_GRANT_1: begin
        bus.request = m1.request && !timeout_fire;
        bus.rw      = m1.rw;
        bus.address = m1.address;
        bus.wdata   = m1.wdata;
        m1.ready    = bus.ready || timeout_fire;
        m1.rdata    = bus.ready ? bus.rdata : BUS_TIMEOUT_RDATA;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// tb/tb_cpu_bus_arbiter.sv - self-checking bench for cpu_bus_arbiter against a transaction-level model
module tb_cpu_bus_arbiter;

  localparam int TO = 8;

  logic       clock;
  logic       reset_n;
  logic [1:0] grant;
  logic       timeout;

  int n_tests = 0;
  int n_fail  = 0;
  bit last_winner = 1'b0;

  cpu_bus_arbiter_if m0_if ();
  cpu_bus_arbiter_if m1_if ();
  cpu_bus_arbiter_if bus_if ();

  cpu_bus_arbiter #(
    .TIMEOUT (TO)
  ) dut (
    .i_clock   (clock),
    .i_reset   (reset_n),
    .m0        (m0_if),
    .m1        (m1_if),
    .bus       (bus_if),
    .o_grant   (grant),
    .o_timeout (timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic drive_port(input bit p, input bit req, input bit rw,
                            input logic [31:0] adr, input logic [31:0] wd);
    if (p) begin
      m1_if.request = req; m1_if.rw = rw; m1_if.address = adr; m1_if.wdata = wd;
    end else begin
      m0_if.request = req; m0_if.rw = rw; m0_if.address = adr; m0_if.wdata = wd;
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, " grant"},    32'(grant),          32'h0);
    check({tag, " bus_req"},  32'(bus_if.request), 32'h0);
    check({tag, " bus_addr"}, bus_if.address,      32'h0);
    check({tag, " m0_rdy"},   32'(m0_if.ready),    32'h0);
    check({tag, " m1_rdy"},   32'(m1_if.ready),    32'h0);
    check({tag, " timeout"},  32'(timeout),        32'h0);
  endtask

  // One arbitration round: the requested ports raise request together in an idle
  // cycle; the model orders them by the tie rule and plays the bus slave, answering
  // each grant in its lat-th cycle, or never when lat exceeds the watchdog limit.
  task automatic run_round(input bit rq0, input bit rq1, input int lat0, input int lat1,
                           input bit rw0, input bit rw1,
                           input logic [31:0] a0, input logic [31:0] a1,
                           input logic [31:0] w0, input logic [31:0] w1,
                           input logic [31:0] r0, input logic [31:0] r1);
    int          order[$];
    int          lat[2];
    logic [31:0] ad[2], wd[2], rd[2];
    bit          rwv[2];
    int          p, dur, first;
    bit          done_ok, last;

    lat[0] = lat0; lat[1] = lat1; ad[0] = a0; ad[1] = a1;
    wd[0] = w0; wd[1] = w1; rd[0] = r0; rd[1] = r1; rwv[0] = rw0; rwv[1] = rw1;

    if (rq0 && rq1) begin
`ifdef CPU_BUS_ARBITER_ROUND_ROBIN_EN
      first = last_winner ? 0 : 1;
`else
      first = 1;
`endif
      order.push_back(first);
      order.push_back(1 - first);
    end else if (rq0) begin
      order.push_back(0);
    end else if (rq1) begin
      order.push_back(1);
    end

    @(negedge clock);
    drive_port(1'b0, rq0, rw0, a0, w0);
    drive_port(1'b1, rq1, rw1, a1, w1);
    #1 check_idle("arb");

    foreach (order[k]) begin
      p       = order[k];
      done_ok = (lat[p] <= TO);
      dur     = done_ok ? lat[p] : TO;
      for (int c = 1; c <= dur; c++) begin
        last = (c == dur);
        @(negedge clock);
        bus_if.ready = last && done_ok;
        bus_if.rdata = (last && done_ok) ? rd[p] : $urandom();
        #1;
        check("grant",     32'(grant), (p == 1) ? 32'h2 : 32'h1);
        check("bus_req",   32'(bus_if.request), (last && !done_ok) ? 32'h0 : 32'h1);
        check("bus_addr",  bus_if.address, ad[p]);
        check("bus_wdata", bus_if.wdata, wd[p]);
        check("bus_rw",    32'(bus_if.rw), 32'(rwv[p]));
        check("rdy_own",   32'((p == 1) ? m1_if.ready : m0_if.ready), 32'(last));
        check("rdy_other", 32'((p == 1) ? m0_if.ready : m1_if.ready), 32'h0);
        check("timeout",   32'(timeout), 32'(last && !done_ok));
        if (last) begin
          check("rdata", (p == 1) ? m1_if.rdata : m0_if.rdata, done_ok ? rd[p] : 32'h0);
        end
      end
      if (done_ok) last_winner = (p == 1);
      @(negedge clock);
      bus_if.ready = 1'b0;
      drive_port(p[0], 1'b0, 1'b0, 32'h0, 32'h0);
      #1 check_idle("gap");
    end
  endtask

  initial begin
    bit rq0, rq1;
    int pattern;

    reset_n = 1'b0;
    drive_port(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive_port(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    bus_if.ready = 1'b0;
    bus_if.rdata = 32'h0;
    repeat (2) @(negedge clock);
    #1 check_idle("reset");
    check("reset m0_rdata", m0_if.rdata, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;

    // m0 read, ready in 3rd grant cycle
    run_round(1'b1, 1'b0, 3, 0, 1'b0, 1'b0, 32'h0000_0100, 32'h0, 32'h0, 32'h0,
              32'hCAFE_F00D, 32'h0);

    // simultaneous requests, m1 write
    run_round(1'b1, 1'b1, 2, 4, 1'b0, 1'b1, 32'h0000_0200, 32'h2000_0000, 32'h0,
              32'h1234_5678, 32'h0BAD_BEEF, 32'h0);

    // watchdog: never ready, ready exactly on the limit, one past the limit
    run_round(1'b0, 1'b1, 0, 100, 1'b0, 1'b0, 32'h0, 32'h0000_0300, 32'h0, 32'h0,
              32'h0, 32'hFFFF_FFFF);
    run_round(1'b1, 1'b0, TO, 0, 1'b0, 1'b0, 32'h0000_0304, 32'h0, 32'h0, 32'h0,
              32'h5A5A_A5A5, 32'h0);
    run_round(1'b1, 1'b0, TO + 1, 0, 1'b1, 1'b0, 32'h0000_0308, 32'h0, 32'h7777_0000,
              32'h0, 32'h1111_1111, 32'h0);

    // asynchronous reset mid-grant with the bus stalled
    @(negedge clock);
    drive_port(1'b0, 1'b1, 1'b0, 32'h0000_0400, 32'h0);
    @(negedge clock);
    #1 check("pre-reset grant", 32'(grant), 32'h1);
    @(negedge clock);
    reset_n = 1'b0;
    #1 check_idle("async reset");
    @(negedge clock);
    drive_port(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1 check("reset m0_rdy", 32'(m0_if.ready), 32'h0);
    reset_n = 1'b1;
    last_winner = 1'b0;
    run_round(1'b0, 1'b1, 2, 2, 1'b0, 1'b0, 32'h0, 32'h0000_0500, 32'h0, 32'h0,
              32'h0, 32'h5555_0001);

    // stray bus ready while idle
    @(negedge clock);
    bus_if.ready = 1'b1;
    bus_if.rdata = 32'hDEAD_BEEF;
    #1 check_idle("idle ready");
    @(negedge clock);
    bus_if.ready = 1'b0;
    #1 check_idle("after idle ready");

    // m0 aborts mid-grant
    @(negedge clock);
    drive_port(1'b0, 1'b1, 1'b0, 32'h0000_0600, 32'h0);
    @(negedge clock);
    #1 check("abort grant", 32'(grant), 32'h1);
    @(negedge clock);
    drive_port(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1 check("abort bus_req", 32'(bus_if.request), 32'h0);
    check("abort m0_rdy", 32'(m0_if.ready), 32'h0);
    @(negedge clock);
    #1 check_idle("after abort");

    // randomized rounds
    for (int i = 0; i < 40; i++) begin
      pattern = $urandom_range(1, 3);
      rq0 = (pattern & 1) != 0;
      rq1 = (pattern & 2) != 0;
      run_round(rq0, rq1, $urandom_range(1, TO + 3), $urandom_range(1, TO + 3),
                1'($urandom()), 1'($urandom()), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
